// File: rtl/order_link_tx_pkg.sv
// Shared definitions for the order exchange link (transmitter and receiver).
//   - tx_state_e : transmitter FSM state encoding
//   - LINK_*     : default link timing, common to both ends of the link
//   - level_w    : width of a FIFO occupancy count for a given depth
//   - cnt_w      : width of a 0..n-1 counter, never narrower than one bit
package order_link_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } tx_state_e;

    localparam int unsigned LINK_BIT_CYCLES = 3;
    localparam int unsigned LINK_GAP_CYCLES = 2;

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous first-word-fall-through FIFO for queued order words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty) and head-of-queue word
//   level      : number of stored words
//   full/empty : occupancy flags derived from level
module order_fifo
    import order_link_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push while full is refused even if a pop frees a slot on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/order_link_tx.sv
// Serial order transmitter: queues pushed order words and sends each one
// MSB-first on data_out, framed by en_out, with optional even parity and a
// minimum low gap on en_out between frames.
// Ports:
//   clk, CPU_RESETN        : clock, asynchronous active-low reset
//   order_in/valid/ready   : push port into the order queue
//   ovf_clr                : clears the sticky overflow flag
//   data_out, en_out       : registered serial data and frame enable
//   busy                   : frame active or words queued
//   level                  : queued words, excluding the one in flight
//   overflow               : sticky, a push was dropped because the queue was full
module order_link_tx
    import order_link_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BIT_CYCLES = LINK_BIT_CYCLES,
    parameter int unsigned GAP_CYCLES = LINK_GAP_CYCLES,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic                        clk,
    input  logic                        CPU_RESETN,
    input  logic [DATA_W-1:0]           order_in,
    input  logic                        order_valid,
    output logic                        order_ready,
    input  logic                        ovf_clr,
    output logic                        data_out,
    output logic                        en_out,
    output logic                        busy,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow
);

    localparam int unsigned BW = cnt_w(DATA_W);
    localparam int unsigned PW = cnt_w(BIT_CYCLES);
    localparam int unsigned GW = cnt_w(GAP_CYCLES);
    // The IDLE cycle before the next pop is itself a low cycle, so GAP lasts one less.
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    tx_state_e         state, state_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [PW-1:0]     per_cnt, per_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic [DATA_W-1:0] sh_reg, sh_nxt;
    logic              par_bit, par_nxt;
    logic              data_nxt, en_nxt;
    logic              pop_c, push_c, drop_c, frame_done;
    logic              per_last, bit_last;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    assign order_ready = ~fifo_full;
    assign push_c      = order_valid & order_ready;
    assign drop_c      = order_valid & ~order_ready;
    assign busy        = (state != IDLE) | (level != '0);
    assign per_last    = (per_cnt == PW'(BIT_CYCLES - 1));
    assign bit_last    = (bit_cnt == BW'(DATA_W - 1));

    order_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (CPU_RESETN),
        .push  (push_c),
        .pop   (pop_c),
        .din   (order_in),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State, counters and registered line outputs.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            per_cnt  <= '0;
            gap_cnt  <= '0;
            sh_reg   <= '0;
            par_bit  <= 1'b0;
            data_out <= 1'b0;
            en_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            per_cnt  <= per_nxt;
            gap_cnt  <= gap_nxt;
            sh_reg   <= sh_nxt;
            par_bit  <= par_nxt;
            data_out <= data_nxt;
            en_out   <= en_nxt;
        end
    end

    // Sticky overflow: a drop on the same edge as a clear wins.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN)  overflow <= 1'b0;
        else if (drop_c)  overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        bit_nxt    = bit_cnt;
        per_nxt    = per_cnt;
        gap_nxt    = gap_cnt;
        sh_nxt     = sh_reg;
        par_nxt    = par_bit;
        data_nxt   = data_out;
        en_nxt     = en_out;
        pop_c      = 1'b0;
        frame_done = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    sh_nxt    = fifo_dout;
                    // Parity taken at load since the shift register discards bits.
                    par_nxt   = ^fifo_dout;
                    data_nxt  = fifo_dout[DATA_W-1];
                    en_nxt    = 1'b1;
                    bit_nxt   = '0;
                    per_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (per_last) begin
                    per_nxt = '0;
                    if (bit_last) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            data_nxt  = par_bit;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end else begin
                        bit_nxt  = bit_cnt + BW'(1);
                        sh_nxt   = {sh_reg[DATA_W-2:0], 1'b0};
                        data_nxt = sh_reg[DATA_W-2];
                    end
                end else begin
                    per_nxt = per_cnt + PW'(1);
                end
            end
            PARITY: begin
                if (per_last) begin
                    per_nxt    = '0;
                    frame_done = 1'b1;
                end else begin
                    per_nxt = per_cnt + PW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_LAST)) state_nxt = IDLE;
                else                          gap_nxt   = gap_cnt + GW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // Common end-of-frame: drop the lines and start the inter-frame gap.
        if (frame_done) begin
            en_nxt    = 1'b0;
            data_nxt  = 1'b0;
            gap_nxt   = '0;
            state_nxt = (GAP_CYCLES > 1) ? GAP : IDLE;
        end
    end

endmodule

// File: tb/tb_order_link_tx.sv
// Directed bench for order_link_tx using three configurations:
//   a: 8-bit, 2 cycles/bit, no parity   b: as a with parity   c: 32-bit, 1 cycle/bit
module tb_order_link_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  ord_a, ord_b;
    logic [31:0] ord_c;
    logic        val_a, val_b, val_c, clr_a, clr_b, clr_c;
    logic        rdy_a, rdy_b, rdy_c, dat_a, dat_b, dat_c, en_a, en_b, en_c;
    logic        busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
    logic [2:0]  lvl_a, lvl_b, lvl_c;

    int n_tests = 0;
    int n_fail  = 0;

    order_link_tx #(.DATA_W(8), .DEPTH(4), .BIT_CYCLES(2), .GAP_CYCLES(2), .PARITY_EN(0)) u_a (
        .clk(clk), .CPU_RESETN(rst_n), .order_in(ord_a), .order_valid(val_a),
        .order_ready(rdy_a), .ovf_clr(clr_a), .data_out(dat_a), .en_out(en_a),
        .busy(busy_a), .level(lvl_a), .overflow(ovf_a));

    order_link_tx #(.DATA_W(8), .DEPTH(4), .BIT_CYCLES(2), .GAP_CYCLES(2), .PARITY_EN(1)) u_b (
        .clk(clk), .CPU_RESETN(rst_n), .order_in(ord_b), .order_valid(val_b),
        .order_ready(rdy_b), .ovf_clr(clr_b), .data_out(dat_b), .en_out(en_b),
        .busy(busy_b), .level(lvl_b), .overflow(ovf_b));

    order_link_tx #(.DATA_W(32), .DEPTH(4), .BIT_CYCLES(1), .GAP_CYCLES(2), .PARITY_EN(0)) u_c (
        .clk(clk), .CPU_RESETN(rst_n), .order_in(ord_c), .order_valid(val_c),
        .order_ready(rdy_c), .ovf_clr(clr_c), .data_out(dat_c), .en_out(en_c),
        .busy(busy_c), .level(lvl_c), .overflow(ovf_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame decoder for instance a: one word per en_a pulse, sampled once per bit.
    logic [7:0] frames_q[$];
    int         lens_q[$];
    logic       mon_act  = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_word = '0;

    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (en_a) begin
            if (!mon_act) begin
                mon_act  = 1'b1;
                mon_cnt  = 0;
                mon_word = '0;
            end
            if (mon_cnt % 2 == 0) mon_word = {mon_word[6:0], dat_a};
            mon_cnt++;
        end else if (mon_act) begin
            mon_act = 1'b0;
            frames_q.push_back(mon_word);
            lens_q.push_back(mon_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  w8;
    logic [31:0] w32;
    logic [7:0]  b_w [2] = '{8'hA5, 8'h01};
    int          b_s [2] = '{1, 21};
    logic [7:0]  t3  [6] = '{8'h3C, 8'h81, 8'h5A, 8'hC3, 8'h7E, 8'h99};
    logic [7:0]  t4  [4] = '{8'h11, 8'hB2, 8'h4D, 8'h6C};
    logic        exp_en, exp_d;
    int          idx, hi_cnt;

    initial begin
        rst_n = 1'b0;
        ord_a = '0; ord_b = '0; ord_c = '0;
        val_a = 0; val_b = 0; val_c = 0;
        clr_a = 0; clr_b = 0; clr_c = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en_a",   en_a,   1'b0);
        check("rst_dat_a",  dat_a,  1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_ovf_a",  ovf_a,  1'b0);
        check("rst_rdy_a",  rdy_a,  1'b1);
        check("rst_lvl_a",  lvl_a,  3'd0);
        check("rst_en_b",   en_b,   1'b0);
        check("rst_en_c",   en_c,   1'b0);
        rst_n = 1'b1;
        tick();

        // Single 0xA5 frame, 2 cycles per bit, then a 2-cycle gap.
        w8 = 8'hA5;
        ord_a = w8; val_a = 1;
        tick();
        val_a = 0;
        check("t1_lvl_push", lvl_a,  3'd1);
        check("t1_en_pre",   en_a,   1'b0);
        check("t1_busy_pre", busy_a, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("t1_en",  en_a,  1'b1);
            check("t1_dat", dat_a, w8[7 - (c - 1) / 2]);
        end
        tick();
        check("t1_en_gap1",   en_a,   1'b0);
        check("t1_dat_gap1",  dat_a,  1'b0);
        check("t1_busy_gap1", busy_a, 1'b1);
        tick();
        check("t1_en_gap2",   en_a,   1'b0);
        check("t1_busy_done", busy_a, 1'b0);
        check("t1_lvl_done",  lvl_a,  3'd0);

        // Parity config: 0xA5 then 0x01, 18-cycle frames separated by 2 low cycles.
        ord_b = b_w[0]; val_b = 1;
        tick();
        ord_b = b_w[1];
        tick();
        val_b = 0;
        check("t2_en_c1", en_b, 1'b1);
        for (int c = 2; c <= 42; c++) begin
            tick();
            exp_en = 1'b0;
            exp_d  = 1'b0;
            for (int f = 0; f < 2; f++) begin
                if (c >= b_s[f] && c < b_s[f] + 18) begin
                    exp_en = 1'b1;
                    idx = (c - b_s[f]) / 2;
                    w8  = b_w[f];
                    exp_d = (idx < 8) ? w8[7 - idx] : ^w8;
                end
            end
            check("t2_en",  en_b,  exp_en);
            check("t2_dat", dat_b, exp_d);
            if (c == 39) check("t2_busy_gap",  busy_b, 1'b1);
            if (c == 40) check("t2_busy_idle", busy_b, 1'b0);
        end

        // Six back-to-back pushes into depth 4: fifth fills, sixth is dropped.
        frames_q.delete();
        lens_q.delete();
        for (int i = 0; i < 6; i++) begin
            ord_a = t3[i]; val_a = 1;
            tick();
            if (i == 1) check("t3_lvl_pushpop", lvl_a, 3'd1);
            if (i == 4) begin
                check("t3_lvl_full", lvl_a, 3'd4);
                check("t3_rdy_full", rdy_a, 1'b0);
                check("t3_ovf_pre",  ovf_a, 1'b0);
            end
            if (i == 5) begin
                check("t3_ovf_set",  ovf_a, 1'b1);
                check("t3_lvl_drop", lvl_a, 3'd4);
            end
        end
        val_a = 0; clr_a = 1;
        tick();
        check("t3_ovf_clr", ovf_a, 1'b0);
        ord_a = 8'hEE; val_a = 1; clr_a = 1;
        tick();
        check("t3_ovf_drop_and_clr", ovf_a, 1'b1);
        check("t3_lvl_still_full",   lvl_a, 3'd4);
        val_a = 0; clr_a = 1;
        tick();
        clr_a = 0;
        check("t3_ovf_clr2", ovf_a, 1'b0);
        for (int k = 0; k < 300 && busy_a; k++) tick();
        tick();
        tick();
        check("t3_nframes", frames_q.size(), 5);
        for (int i = 0; i < 5 && i < frames_q.size(); i++) begin
            check("t3_word", frames_q[i], t3[i]);
            check("t3_len",  lens_q[i],   16);
        end

        // Push and pop on the same edge with two words queued.
        frames_q.delete();
        lens_q.delete();
        for (int i = 0; i < 3; i++) begin
            ord_a = t4[i]; val_a = 1;
            tick();
        end
        val_a = 0;
        repeat (16) tick();
        check("t4_lvl_before", lvl_a, 3'd2);
        check("t4_en_before",  en_a,  1'b0);
        ord_a = t4[3]; val_a = 1;
        tick();
        val_a = 0;
        check("t4_lvl_after", lvl_a, 3'd2);
        check("t4_en_after",  en_a,  1'b1);
        w8 = t4[1];
        check("t4_dat_msb",   dat_a, w8[7]);
        for (int k = 0; k < 300 && busy_a; k++) tick();
        tick();
        tick();
        check("t4_nframes", frames_q.size(), 4);
        for (int i = 0; i < 4 && i < frames_q.size(); i++)
            check("t4_word", frames_q[i], t4[i]);

        // Asynchronous reset in the middle of bit 3.
        ord_a = 8'hFF; val_a = 1;
        tick();
        ord_a = 8'h0F;
        tick();
        val_a = 0;
        repeat (6) tick();
        check("t5_en_mid",  en_a,  1'b1);
        check("t5_dat_mid", dat_a, 1'b1);
        check("t5_lvl_mid", lvl_a, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_en_rst",   en_a,   1'b0);
        check("t5_dat_rst",  dat_a,  1'b0);
        check("t5_lvl_rst",  lvl_a,  3'd0);
        check("t5_busy_rst", busy_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (en_a) hi_cnt++;
        end
        check("t5_en_after_rel", hi_cnt, 0);
        check("t5_lvl_after_rel", lvl_a, 3'd0);

        // 32-bit word at one cycle per bit.
        w32 = 32'h1100_4001;
        ord_c = w32; val_c = 1;
        tick();
        val_c = 0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            check("t6_en",  en_c,  1'b1);
            check("t6_dat", dat_c, w32[32 - c]);
        end
        tick();
        check("t6_en_end", en_c, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
